// File: rtl/udp_cmd_pkg.sv
// udp_cmd_pkg: opcodes, frame field positions, decoder states and header check
package udp_cmd_pkg;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam int SOP_BIT = 32;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 24;
  localparam int LEN_HI  = 15;
  localparam int LEN_LO  = 0;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WREQ, RREQ, RWAIT, RSP, DROP} state_e;
  function automatic logic hdr_bad(input logic [31:0] w, input int unsigned max_len);
    logic [7:0] op;
    logic [15:0] n;
    op = w[OP_HI:OP_LO];
    n = w[LEN_HI:LEN_LO];
    return !(op == OP_WRITE || op == OP_READ) || n == 16'd0 || 32'(n) > max_len;
  endfunction
endpackage

// File: rtl/udp_cmd_fetch.sv
// udp_cmd_fetch: FIFO read adapter with one-cycle capture into a holding register
module udp_cmd_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic        fifo_rd_en,
  input  logic [32:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  output logic        word_valid,
  output logic [32:0] word_data,
  input  logic        word_take
);
  logic        pend_q;
  logic        vld_q;
  logic [32:0] hold_q;
  // read only when nothing is in flight and the holding register is free or being drained
  always_comb fifo_rd_en = !rst && !fifo_rd_empty && !pend_q && (!vld_q || word_take);
  // word arrives the cycle after the strobe and is parked until the decoder takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= fifo_rd_en;
      vld_q  <= pend_q || (vld_q && !word_take);
      if (pend_q) hold_q <= fifo_rd_data;
    end
  end
  assign word_valid = vld_q;
  assign word_data  = hold_q;
endmodule

// File: rtl/udp_cmd_parser.sv
// udp_cmd_parser: decodes UDP command frames into register-bus accesses and read responses
module udp_cmd_parser
  import udp_cmd_pkg::*;
#(
  parameter logic [31:0] ADDR_INC = 32'd1,
  parameter int unsigned MAX_LEN  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fifo_rd_en,
  input  logic [32:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [32:0] rsp_data,
  output logic        err_pulse
);
  state_e      state_q;
  logic [31:0] hdr_q;
  logic [31:0] addr_q;
  logic [15:0] cnt_q;
  logic        word_valid;
  logic [32:0] word;
  logic        take;
  logic        sop;
  logic        bad;
  logic        last;
  udp_cmd_fetch u_fetch (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .word_valid   (word_valid),
    .word_data    (word),
    .word_take    (take)
  );
  // words are consumed only in the states that fetch; last flags the final beat of a frame
  always_comb begin
    take = word_valid && (state_q inside {IDLE, ADDR, WDATA, DROP});
    sop  = word[SOP_BIT];
    bad  = hdr_bad(word[31:0], MAX_LEN);
    last = (cnt_q + 16'd1) == hdr_q[LEN_HI:LEN_LO];
  end
  // decoder FSM; any SOP word is re-decoded as a header, flagging an error if it cut a frame short
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hdr_q         <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      bus_req_valid <= 1'b0;
      bus_req_write <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      err_pulse     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (take && sop) begin
        err_pulse <= bad || (state_q inside {ADDR, WDATA});
        hdr_q     <= word[31:0];
        state_q   <= bad ? DROP : ADDR;
      end else if (take) begin
        case (state_q)
          IDLE: begin
            err_pulse <= 1'b1;
            state_q   <= DROP;
          end
          ADDR: begin
            addr_q <= word[31:0];
            cnt_q  <= '0;
            if (hdr_q[OP_HI:OP_LO] == OP_WRITE) state_q <= WDATA;
            else begin
              state_q   <= RREQ;
              rsp_valid <= 1'b1;
              rsp_data  <= {1'b1, hdr_q};
            end
          end
          WDATA: begin
            bus_req_valid <= 1'b1;
            bus_req_write <= 1'b1;
            bus_req_addr  <= addr_q;
            bus_req_wdata <= word[31:0];
            state_q       <= WREQ;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          WREQ: if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            addr_q        <= addr_q + ADDR_INC;
            cnt_q         <= cnt_q + 16'd1;
            state_q       <= last ? IDLE : WDATA;
          end
          RREQ: if (rsp_valid && rsp_ready) begin
            rsp_valid     <= 1'b0;
            bus_req_valid <= 1'b1;
            bus_req_write <= 1'b0;
            bus_req_addr  <= addr_q;
          end else if (bus_req_valid && bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state_q       <= RWAIT;
          end
          RWAIT: if (bus_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {1'b0, bus_rsp_rdata};
            state_q   <= RSP;
          end
          RSP: if (rsp_ready) begin
            rsp_valid <= 1'b0;
            addr_q    <= addr_q + ADDR_INC;
            cnt_q     <= cnt_q + 16'd1;
            if (last) state_q <= IDLE;
            else begin
              state_q       <= RREQ;
              bus_req_valid <= 1'b1;
              bus_req_write <= 1'b0;
              bus_req_addr  <= addr_q + ADDR_INC;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_udp_cmd_parser.sv
// tb_udp_cmd_parser: directed frames against FIFO, bus and response-sink models
module tb_udp_cmd_parser;
  import udp_cmd_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd_en;
  logic [32:0] fifo_rd_data = '0;
  logic        fifo_rd_empty;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic        rsp_valid, rsp_ready, err_pulse;
  logic [32:0] rsp_data;
  int checks = 0, errors = 0;
  logic [32:0] fmem [0:1023];
  int wp = 0, rp = 0;
  logic        bw [0:1023];
  logic [31:0] ba [0:1023];
  logic [31:0] bd [0:1023];
  logic [32:0] rs [0:1023];
  int bn = 0, rn = 0, ecnt = 0, stab_err = 0, seq_err = 0, fifo_err = 0;
  int lat = 3, lat_cnt = 0, outst = 0;
  logic [31:0] rd_addr = '0;
  logic pbv = 0, pbr = 0, prv = 0, prr = 0;
  logic [64:0] pb = '0;
  logic [32:0] pr = '0;
  int b0, r0, e0;

  udp_cmd_parser #(.ADDR_INC(32'd1), .MAX_LEN(256)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [32:0] w);
    fmem[wp] = w;
    wp++;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag);
    int t = 0;
    while (!rsp_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk(tag, rsp_valid, 1);
  endtask

  task automatic pulse_ready;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  assign fifo_rd_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wp == rp) fifo_err++;
      fifo_rd_data <= fmem[rp];
      rp <= rp + 1;
    end
  end

  always @(posedge clk) begin
    bus_rsp_valid <= 1'b0;
    if (rst) begin
      lat_cnt = 0;
      outst = 0;
    end else begin
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus_rsp_valid <= 1'b1;
          bus_rsp_rdata <= rdm(rd_addr);
        end
      end
      if (bus_req_valid && bus_req_ready) begin
        bw[bn] = bus_req_write;
        ba[bn] = bus_req_addr;
        bd[bn] = bus_req_wdata;
        bn++;
        if (!bus_req_write) begin
          if (outst != 0) seq_err++;
          outst = 1;
          rd_addr = bus_req_addr;
          lat_cnt = lat;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rs[rn] = rsp_data;
        rn++;
        if (!rsp_data[32]) outst = 0;
      end
      if (err_pulse) ecnt++;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (pbv && !pbr && (!bus_req_valid || {bus_req_write, bus_req_addr, bus_req_wdata} != pb)) stab_err++;
      if (prv && !prr && (!rsp_valid || rsp_data != pr)) stab_err++;
    end
    pbv = bus_req_valid && !rst;
    pbr = bus_req_ready;
    pb  = {bus_req_write, bus_req_addr, bus_req_wdata};
    prv = rsp_valid && !rst;
    prr = rsp_ready;
    pr  = rsp_data;
  end

  initial begin
    bus_req_ready = 1'b1;
    rsp_ready = 1'b1;
    run(3);
    chk("rst_outs", {fifo_rd_en, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata,
                     rsp_valid, rsp_data, err_pulse}, 0);
    rst = 1'b0;

    b0 = bn; e0 = ecnt;
    push(33'h1_0100_0003); push(33'h0_0000_0010);
    push(33'h0_0000_000A); push(33'h0_0000_000B); push(33'h0_0000_000C);
    run(60);
    chk("w3_cnt", bn - b0, 3);
    for (int k = 0; k < 3; k++) begin
      chk("w3_wr", bw[b0+k], 1);
      chk("w3_addr", ba[b0+k], 32'h10 + k);
      chk("w3_data", bd[b0+k], 32'hA + k);
    end
    chk("w3_err", ecnt - e0, 0);

    b0 = bn; r0 = rn; lat = 3;
    push(33'h1_0200_0002); push(33'h0_FFFF_FFFF);
    run(80);
    chk("rd_bus_cnt", bn - b0, 2);
    chk("rd_bus_a0", {bw[b0], ba[b0]}, {1'b0, 32'hFFFF_FFFF});
    chk("rd_bus_a1", {bw[b0+1], ba[b0+1]}, {1'b0, 32'h0000_0000});
    chk("rd_rsp_cnt", rn - r0, 3);
    chk("rd_echo", rs[r0], 33'h1_0200_0002);
    chk("rd_d0", rs[r0+1], {1'b0, rdm(32'hFFFF_FFFF)});
    chk("rd_d1_wrap", rs[r0+2], {1'b0, rdm(32'h0)});

    b0 = bn; r0 = rn; lat = 2; rsp_ready = 1'b0;
    push(33'h1_0200_0002); push(33'h0_0000_0100);
    wait_rsp("bp_echo_wait");
    run(5);
    chk("bp_echo_hold", {rsp_valid, rsp_data}, {1'b1, 33'h1_0200_0002});
    chk("bp_no_early_rd", bn - b0, 0);
    pulse_ready;
    for (int k = 0; k < 2; k++) begin
      wait_rsp("bp_data_wait");
      run(5);
      chk("bp_data_hold", {rsp_valid, rsp_data}, {1'b1, 1'b0, rdm(32'h100 + k)});
      chk("bp_one_rd", bn - b0, k + 1);
      pulse_ready;
    end
    run(10);
    rsp_ready = 1'b1;
    chk("bp_rsp_cnt", rn - r0, 3);
    chk("bp_addr1", ba[b0+1], 32'h101);

    b0 = bn; e0 = ecnt;
    push(33'h1_0700_0001); push(33'h0_0000_1234); push(33'h0_0000_5678);
    push(33'h1_0100_0001); push(33'h0_0000_0020); push(33'h0_0000_DEAD);
    run(60);
    chk("op_err", ecnt - e0, 1);
    chk("op_cnt", bn - b0, 1);
    chk("op_wr", {bw[b0], ba[b0], bd[b0]}, {1'b1, 32'h20, 32'hDEAD});

    b0 = bn; e0 = ecnt;
    push(33'h1_0100_0000); push(33'h1_0100_0001); push(33'h0_0000_0021); push(33'h0_0000_0055);
    push(33'h1_0100_0101); push(33'h1_0100_0001); push(33'h0_0000_0022); push(33'h0_0000_0066);
    run(80);
    chk("len_err", ecnt - e0, 2);
    chk("len_cnt", bn - b0, 2);
    chk("len_wr0", {ba[b0], bd[b0]}, {32'h21, 32'h55});
    chk("len_wr1", {ba[b0+1], bd[b0+1]}, {32'h22, 32'h66});

    b0 = bn; e0 = ecnt;
    push(33'h1_0100_0100); push(33'h0_0000_1000);
    for (int k = 0; k < 256; k++) push({1'b0, 32'(k)});
    run(1500);
    chk("max_cnt", bn - b0, 256);
    chk("max_first", {ba[b0], bd[b0]}, {32'h1000, 32'h0});
    chk("max_last", {ba[b0+255], bd[b0+255]}, {32'h10FF, 32'hFF});
    chk("max_err", ecnt - e0, 0);

    b0 = bn; r0 = rn; e0 = ecnt;
    push(33'h1_0100_0004); push(33'h0_0000_0030); push(33'h0_0000_00D0); push(33'h0_0000_00D1);
    push(33'h1_0200_0001); push(33'h0_0000_0040);
    run(80);
    chk("cut_err", ecnt - e0, 1);
    chk("cut_bus_cnt", bn - b0, 3);
    chk("cut_w0", {bw[b0], ba[b0], bd[b0]}, {1'b1, 32'h30, 32'hD0});
    chk("cut_w1", {bw[b0+1], ba[b0+1], bd[b0+1]}, {1'b1, 32'h31, 32'hD1});
    chk("cut_rd", {bw[b0+2], ba[b0+2]}, {1'b0, 32'h40});
    chk("cut_rsp_cnt", rn - r0, 2);
    chk("cut_echo", rs[r0], 33'h1_0200_0001);
    chk("cut_data", rs[r0+1], {1'b0, rdm(32'h40)});

    b0 = bn;
    bus_req_ready = 1'b0;
    push(33'h1_0100_0001); push(33'h0_0000_0050); push(33'h0_0000_0077);
    begin
      int t = 0;
      while (!bus_req_valid && t < 60) begin
        @(negedge clk);
        t++;
      end
    end
    chk("mr_wreq", {bus_req_valid, bus_req_addr, bus_req_wdata}, {1'b1, 32'h50, 32'h77});
    rst = 1'b1;
    @(negedge clk);
    chk("mr_outs", {fifo_rd_en, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata,
                    rsp_valid, rsp_data, err_pulse}, 0);
    chk("mr_state", dut.state_q, IDLE);
    rst = 1'b0;
    bus_req_ready = 1'b1;
    push(33'h1_0100_0001); push(33'h0_0000_0060); push(33'h0_0000_0088);
    run(40);
    chk("mr_cnt", bn - b0, 1);
    chk("mr_wr", {bw[b0], ba[b0], bd[b0]}, {1'b1, 32'h60, 32'h88});

    chk("stable", stab_err, 0);
    chk("one_outstanding", seq_err, 0);
    chk("fifo_underflow", fifo_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
